// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared widths, frame magic, loader state and error encodings
package imem_loader_pkg;
    localparam int IMEM_WORD_W = 16;
    localparam int IMEM_ADDR_W = 16;
    localparam logic [15:0] IMEM_MAGIC = 16'h4C44;
    typedef enum logic [2:0] {
        S_IDLE, S_MAGIC, S_ADDR, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
    } ldr_state_t;
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_MAGIC = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: framed host stream to instruction memory writer with checksum check and cpu hold
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WORD_W = IMEM_WORD_W,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter logic [WORD_W-1:0] MAGIC = IMEM_MAGIC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);
    ldr_state_t state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [WORD_W-1:0] rem, rem_n, sum, sum_n;
    logic we_n, acc;
    logic [1:0] err_n;
    assign acc = in_valid & in_ready;
    always_comb begin
        state_n = state;
        addr_n  = addr;
        rem_n   = rem;
        sum_n   = sum;
        we_n    = 1'b0;
        err_n   = err_code;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) begin
                state_n = S_MAGIC;
                err_n   = ERR_NONE;
            end
            S_MAGIC: if (acc) begin
                state_n = (in_data == MAGIC) ? S_ADDR : S_ERR;
                err_n   = (in_data == MAGIC) ? ERR_NONE : ERR_MAGIC;
            end
            S_ADDR: if (acc) begin
                addr_n  = ADDR_W'(in_data);
                state_n = S_LEN;
            end
            S_LEN: if (acc) begin
                rem_n   = in_data;
                sum_n   = '0;
                state_n = (in_data == '0) ? S_CSUM : S_DATA;
            end
            S_DATA: if (acc) begin
                we_n    = 1'b1;
                sum_n   = sum + in_data;
                addr_n  = addr + 1'b1;
                rem_n   = rem - 1'b1;
                state_n = (rem == WORD_W'(1)) ? S_CSUM : S_DATA;
            end
            S_CSUM: if (acc) begin
                state_n = (in_data == sum) ? S_DONE : S_ERR;
                err_n   = (in_data == sum) ? ERR_NONE : ERR_CSUM;
            end
            default: state_n = S_IDLE;
        endcase
    end
    // Handshake and status outputs are registered from the next state so they track state exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            addr      <= '0;
            rem       <= '0;
            sum       <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state    <= state_n;
            addr     <= addr_n;
            rem      <= rem_n;
            sum      <= sum_n;
            in_ready <= state_n inside {S_MAGIC, S_ADDR, S_LEN, S_DATA, S_CSUM};
            mem_we   <= we_n;
            if (we_n) begin
                mem_addr  <= addr;
                mem_wdata <= in_data;
            end
            cpu_hold <= state_n != S_DONE;
            done     <= state_n == S_DONE;
            error    <= state_n == S_ERR;
            err_code <= err_n;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader framing, writes, checksum and reset
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, mem_we, cpu_hold, done, error;
    logic [15:0] mem_addr, mem_wdata;
    logic [1:0]  err_code;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [31:0] wa[$];
    int wc[$];

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_we) begin
        wa.push_back({mem_addr, mem_wdata});
        wc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] w);
        int t = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && t < 50) begin
            tick(1);
            t++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        tick(1);
    endtask

    task automatic settle();
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_cpu_hold", 32'(cpu_hold), 1);
        chk("rst_flags", {29'd0, done, error, err_code[0]}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick(1);

        // 1: basic frame, start with in_valid in the same IDLE cycle
        wa.delete(); wc.delete();
        in_valid = 1'b1; in_data = 16'h4C44;
        chk("t1_idle_ready", 32'(in_ready), 0);
        pulse_start();
        chk("t1_magic_ready", 32'(in_ready), 1);
        chk("t1_no_early_write", wa.size(), 0);
        send(16'h4C44); send(16'h0010); send(16'h0003);
        send(16'h1001); send(16'h2002); send(16'h3003); send(16'h6006);
        chk("t1_done", 32'(done), 1);
        chk("t1_hold", 32'(cpu_hold), 0);
        chk("t1_err", {30'd0, err_code}, 0);
        settle();
        chk("t1_nwrites", wa.size(), 3);
        if (wa.size() == 3) begin
            chk("t1_w0", wa[0], 32'h0010_1001);
            chk("t1_w1", wa[1], 32'h0011_2002);
            chk("t1_w2", wa[2], 32'h0012_3003);
            chk("t1_b2b", 32'(wc[2] - wc[0]), 2);
        end
        pulse_start();
        chk("t1_restart_done", 32'(done), 0);
        chk("t1_restart_hold", 32'(cpu_hold), 1);

        // 2: bad magic, then recover
        wa.delete();
        send(16'h1234);
        chk("t2_error", 32'(error), 1);
        chk("t2_code", {30'd0, err_code}, 1);
        chk("t2_hold", 32'(cpu_hold), 1);
        chk("t2_not_done", 32'(done), 0);
        settle();
        chk("t2_nwrites", wa.size(), 0);
        pulse_start();
        chk("t2_restart_clr", {30'd0, error, err_code[0]}, 0);
        send(16'h4C44); send(16'h0020); send(16'h0001); send(16'h00AA); send(16'h00AA);
        chk("t2_done", {30'd0, done, error}, 2);
        settle();
        chk("t2_w0", wa.size() == 1 ? wa[0] : 32'hDEAD_BEEF, 32'h0020_00AA);

        // 3: address wrap
        wa.delete();
        pulse_start();
        send(16'h4C44); send(16'hFFFF); send(16'h0002); send(16'h000A); send(16'h000B); send(16'h0015);
        chk("t3_done", 32'(done), 1);
        settle();
        chk("t3_nwrites", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("t3_w0", wa[0], 32'hFFFF_000A);
            chk("t3_w1", wa[1], 32'h0000_000B);
        end

        // 4: bad checksum keeps earlier write
        wa.delete();
        pulse_start();
        send(16'h4C44); send(16'h0000); send(16'h0001); send(16'h8000); send(16'h8001);
        chk("t4_error", 32'(error), 1);
        chk("t4_code", {30'd0, err_code}, 2);
        chk("t4_hold", 32'(cpu_hold), 1);
        chk("t4_not_done", 32'(done), 0);
        settle();
        chk("t4_w0", wa.size() == 1 ? wa[0] : 32'hDEAD_BEEF, 32'h0000_8000);

        // 5: gated valid, start mid-DATA ignored, then N=0 frame
        wa.delete();
        pulse_start();
        send(16'h4C44); send(16'h0100); send(16'h0004);
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b0;
            tick($urandom_range(0, 3));
            if (i == 3) begin
                pulse_start();
                chk("t5_start_ignored", {30'd0, in_ready, done}, 2);
            end
            send(16'(i));
        end
        send(16'h000A);
        chk("t5_done", 32'(done), 1);
        settle();
        chk("t5_nwrites", wa.size(), 4);
        for (int i = 0; i < 4 && i < wa.size(); i++)
            chk("t5_w", wa[i], {16'h0100 + 16'(i), 16'(i + 1)});
        wa.delete();
        pulse_start();
        send(16'h4C44); send(16'h0005); send(16'h0000); send(16'h0000);
        chk("t5_n0_done", 32'(done), 1);
        settle();
        chk("t5_n0_nwrites", wa.size(), 0);

        // 6: async reset mid-DATA
        wa.delete();
        pulse_start();
        send(16'h4C44); send(16'h0200); send(16'h0005); send(16'h0001); send(16'h0002);
        in_data = 16'h0003;
        #2 reset = 1'b0;
        #1;
        chk("t6_ready", 32'(in_ready), 0);
        chk("t6_we", 32'(mem_we), 0);
        chk("t6_addr", 32'(mem_addr), 0);
        chk("t6_hold", 32'(cpu_hold), 1);
        tick(2);
        reset = 1'b1;
        tick(4);
        chk("t6_idle", {29'd0, in_ready, done, error}, 0);
        chk("t6_nwrites", wa.size(), 1);
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface that the control unit reads. It accepts a framed stream of 16-bit words from a host over a valid/ready handshake.
- It writes the payload into instruction memory and verifies a checksum.
- It holds the control unit and PE array in hold (`cpu_hold`) until a load completes cleanly.
- It replaces file-based preload of instruction memory for synthesizable builds.

Parameters:
- WORD_W, 16, instruction word width
- ADDR_W, 16, instruction memory address width; addresses wrap modulo 2^ADDR_W
- MAGIC, 16'h4C44, required first word of every frame

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (one clock clk; reset is asynchronous and active-low)
- start  input  1  one-cycle pulse; arms loader for a new frame
- in_valid  input  1  host word valid
- in_data  input  WORD_W  host word
- in_ready  output  1  loader can accept in_data this cycle
- mem_we  output  1  instruction memory write enable
- mem_addr  output  ADDR_W  instruction memory write address
- mem_wdata  output  WORD_W  instruction memory write data
- cpu_hold  output  1  1 = control unit must not fetch or advance pc
- done  output  1  level; frame loaded and checksum matched
- error  output  1  level; frame rejected
- err_code  output  2  0 none, 1 bad magic, 2 bad checksum

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, done=0, error=0, err_code=0.
  - Internal address, length and sum registers are cleared.
  - Reset asserted mid-frame discards the frame; no further writes.
- Handshake:
  - A word transfers on a rising clk edge with in_valid=1 and in_ready=1.
  - in_ready is a registered function of state: 1 in MAGIC, ADDR, LEN, DATA, CSUM; 0 in IDLE, DONE, ERR.
  - in_valid without in_ready is ignored. The host holds in_data until it is accepted.
- States:
  - IDLE: on start, go to MAGIC and set cpu_hold=1, done=0, error=0, err_code=0.
  - MAGIC: on accept, if in_data==MAGIC go to ADDR. Otherwise go to ERR with err_code=1.
  - ADDR: on accept, latch base address, go to LEN.
  - LEN: on accept, latch N=in_data and clear sum. If N==0 go to CSUM, else go to DATA.
  - DATA: on each accept:
    - write mem_addr=current address, mem_wdata=in_data;
    - sum += in_data mod 2^16;
    - address += 1 mod 2^ADDR_W;
    - remaining -= 1; when remaining reaches 0, go to CSUM.
  - CSUM: on accept, if in_data==sum go to DONE, else go to ERR with err_code=2.
  - DONE: done=1, cpu_hold=0. start re-enters MAGIC with cpu_hold=1 and done=0 in the next cycle.
  - ERR: error=1, cpu_hold=1. start re-enters MAGIC and clears error and err_code.
- Write timing:
  - mem_we, mem_addr and mem_wdata are registered: asserted exactly one cycle after the accepting edge, for one cycle per word.
  - Back-to-back accepts produce back-to-back writes.
  - Earlier writes of a frame later rejected for checksum stay in memory; cpu_hold stays 1.
- Boundary conditions:
  - Address wraps from 2^ADDR_W-1 to 0 within a frame.
  - start while in MAGIC..CSUM is ignored.
  - start and in_valid in the same IDLE cycle: only start takes effect; the first word is accepted no earlier than the next cycle.
  - done and error are never both 1.
- Throughput: one word per cycle when in_valid is held high. Frame latency is N+4 accepts, plus 1 cycle to DONE/ERR outputs.

Decomposition:
- Shared package: WORD_W and ADDR_W consistent with the CU word and memory definitions; the MAGIC constant; state encoding (IDLE, MAGIC, ADDR, LEN, DATA, CSUM, DONE, ERR); err_code values.
- No sub-module. The checksum is a single 16-bit accumulator inside imem_loader.

Test Plan:
1. Reset, start, then send 4C44, 0010, 0003, 1001, 2002, 3003, 6006 continuously -> writes mem[0010]=1001, mem[0011]=2002, mem[0012]=3003 on consecutive cycles; done=1, cpu_hold=0, err_code=0.
2. Frame with first word 1234 -> no mem_we ever; error=1, err_code=1, cpu_hold=1; a following start plus a valid frame clears error and ends in done=1.
3. Frame 4C44, FFFF, 0002, 000A, 000B, 0015 -> mem[FFFF]=000A, mem[0000]=000B (wrap); done=1.
4. Frame 4C44, 0000, 0001, 8000, 8001 (correct sum 8000) -> mem[0000]=8000 written; error=1, err_code=2, cpu_hold=1.
5. Randomly gate in_valid and pulse start mid-DATA -> start ignored; data written in order with no duplicates or gaps; N=0 frame (4C44, 0005, 0000, 0000) gives done with zero writes.
6. Assert reset during DATA after 2 of 5 words -> outputs return to reset values immediately; no further mem_we; cpu_hold=1; state IDLE.
